id_ex_stage: RTL and testbench

- ID/EX pipeline register that feeds the execute-stage ALU: opcode, funct3, funct7, operand1, operand2, immediate and PC.
- Captures decoded fields and register-file read data each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, detects load-use hazards, and inserts bubbles on stall or branch flush.

---
 rtl/id_ex_stage.sv | 206 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the execute-stage ALU: captures decoded fields and
// register reads, forwards from EX/MEM and MEM/WB, and raises a load-use stall.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic [6:0]            id_funct7,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_immediate,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_regwrite,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_regwrite,
    input  logic [XLEN-1:0]       memwb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic [XLEN-1:0]       ex_immediate,
    output logic [XLEN-1:0]       ex_operand1,
    output logic [XLEN-1:0]       ex_operand2,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  hazard_stall
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic                  valid_q,    valid_d;
    logic [XLEN-1:0]       pc_q,       pc_d;
    logic [6:0]            opcode_q,   opcode_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [6:0]            funct7_q,   funct7_d;
    logic [XLEN-1:0]       imm_q,      imm_d;
    logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memread_q,  memread_d;

    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_writes_rd;
    logic [6:0] cap_opcode;
    logic       load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            shift_imm;

    // Invalid decode slots are captured with opcode 0 so the ALU outputs 0.
    assign cap_opcode = id_valid ? id_opcode : 7'b0;

    always_comb begin
        id_uses_rs1  = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        id_uses_rs2  = id_opcode inside {OP_REG, OP_BRANCH, OP_STORE};
        id_writes_rd = cap_opcode inside {OP_REG, OP_IMM, OP_AUIPC, OP_LUI, OP_JAL, OP_LOAD};
    end

    always_comb begin
        load_use = valid_q && memread_q && (rd_q != '0) && id_valid &&
                   ((id_uses_rs1 && (id_rs1 == rd_q)) || (id_uses_rs2 && (id_rs2 == rd_q)));
        hazard_stall = load_use && !flush;
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        if (flush || (!stall_in && hazard_stall)) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            opcode_d   = '0;
            funct3_d   = '0;
            funct7_d   = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (!stall_in) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            opcode_d   = cap_opcode;
            funct3_d   = id_funct3;
            funct7_d   = id_funct7;
            imm_d      = id_immediate;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            regwrite_d = id_writes_rd && (id_rd != '0);
            memread_d  = (cap_opcode == OP_LOAD);
            // The register file is written this same edge, so its read data is stale.
            rs1_data_d = (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs1))
                         ? memwb_result : id_rs1_data;
            rs2_data_d = (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs2))
                         ? memwb_result : id_rs2_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    // x0 reads as zero no matter what was captured or what is in flight.
    always_comb begin
        if (rs1_q == '0)
            fwd_rs1 = '0;
        else if (exmem_regwrite && (exmem_rd == rs1_q))
            fwd_rs1 = exmem_result;
        else if (memwb_regwrite && (memwb_rd == rs1_q))
            fwd_rs1 = memwb_result;
        else
            fwd_rs1 = rs1_data_q;

        if (rs2_q == '0)
            fwd_rs2 = '0;
        else if (exmem_regwrite && (exmem_rd == rs2_q))
            fwd_rs2 = exmem_result;
        else if (memwb_regwrite && (memwb_rd == rs2_q))
            fwd_rs2 = memwb_result;
        else
            fwd_rs2 = rs2_data_q;
    end

    assign shift_imm = (opcode_q == OP_IMM) && ((funct3_q == 3'b001) || (funct3_q == 3'b101));

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_opcode     = opcode_q;
    assign ex_funct3     = funct3_q;
    assign ex_funct7     = funct7_q;
    assign ex_immediate  = imm_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_operand1   = fwd_rs1;
    assign ex_operand2   = shift_imm ? {{(XLEN-5){1'b0}}, imm_q[4:0]} : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, all
// compared against a slot-level reference model of the EX stage.
module tb_id_ex_stage;

    localparam logic [6:0] ADD_OP  = 7'b0110011;
    localparam logic [6:0] IMM_OP  = 7'b0010011;
    localparam logic [6:0] AUIPC_OP= 7'b0010111;
    localparam logic [6:0] LUI_OP  = 7'b0110111;
    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] LOAD_OP = 7'b0000011;
    localparam logic [6:0] BR_OP   = 7'b1100011;
    localparam logic [6:0] ST_OP   = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_immediate;
    logic        flush, stall_in;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_immediate, ex_operand1, ex_operand2, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, hazard_stall;

    int checks = 0;
    int errors = 0;

    // One EX slot as the architecture sees it.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic        rw, mr;
    } slot_t;
    slot_t m;

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_immediate(id_immediate),
        .flush(flush), .stall_in(stall_in),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_immediate(ex_immediate), .ex_operand1(ex_operand1),
        .ex_operand2(ex_operand2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {ADD_OP, IMM_OP, AUIPC_OP, LUI_OP, JAL_OP, LOAD_OP};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {LUI_OP, AUIPC_OP, JAL_OP});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {ADD_OP, BR_OP, ST_OP};
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 0) return 32'h0;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_result;
        return stored;
    endfunction

    function automatic logic exp_hazard();
        if (flush || !m.valid || !m.mr || m.rd == 0 || !id_valid) return 1'b0;
        return (uses_rs1(id_opcode) && id_rs1 == m.rd) || (uses_rs2(id_opcode) && id_rs2 == m.rd);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_op2;
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".opcode"}, 32'(ex_opcode), 32'(m.op));
        chk({tag, ".regwrite"}, 32'(ex_regwrite), 32'(m.rw));
        chk({tag, ".memread"}, 32'(ex_memread), 32'(m.mr));
        chk({tag, ".hazard"}, 32'(hazard_stall), 32'(exp_hazard()));
        if (m.valid || reset) begin
            e_op2 = (m.op == IMM_OP && (m.f3 == 3'b001 || m.f3 == 3'b101))
                    ? {27'b0, m.imm[4:0]} : value_of(m.rs2, m.d2);
            chk({tag, ".pc"}, ex_pc, m.pc);
            chk({tag, ".funct3"}, 32'(ex_funct3), 32'(m.f3));
            chk({tag, ".funct7"}, 32'(ex_funct7), 32'(m.f7));
            chk({tag, ".imm"}, ex_immediate, m.imm);
            chk({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
            chk({tag, ".op1"}, ex_operand1, value_of(m.rs1, m.d1));
            chk({tag, ".op2"}, ex_operand2, e_op2);
            chk({tag, ".store"}, ex_store_data, value_of(m.rs2, m.d2));
        end
    endtask

    // Inputs are stable from the preceding negedge, so the model sees what the DUT sees.
    task automatic model_edge();
        slot_t n;
        if (reset) begin
            m = '0;
        end else if (flush) begin
            m = '0;
        end else if (!stall_in) begin
            if (exp_hazard()) begin
                m = '0;
            end else begin
                n = '0;
                n.valid = id_valid;
                n.pc = id_pc;
                n.op = id_valid ? id_opcode : 7'h0;
                n.f3 = id_funct3;
                n.f7 = id_funct7;
                n.imm = id_immediate;
                n.rs1 = id_rs1;
                n.rs2 = id_rs2;
                n.rd = id_rd;
                n.rw = writes_rd(n.op) && id_rd != 0;
                n.mr = (n.op == LOAD_OP);
                n.d1 = (memwb_regwrite && memwb_rd != 0 && memwb_rd == id_rs1) ? memwb_result : id_rs1_data;
                n.d2 = (memwb_regwrite && memwb_rd != 0 && memwb_rd == id_rs2) ? memwb_result : id_rs2_data;
                m = n;
            end
        end
    endtask

    task automatic settle(input string tag);
        #1;
        if (reset) m = '0;
        check_all(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_opcode = 0; id_funct3 = 0; id_funct7 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0; id_immediate = 0;
        flush = 0; stall_in = 0;
        exmem_rd = 0; exmem_regwrite = 0; exmem_result = 0;
        memwb_rd = 0; memwb_regwrite = 0; memwb_result = 0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm);
        id_valid = 1; id_pc = 32'h100 + 32'($urandom_range(0, 255)) * 4;
        id_opcode = op; id_funct3 = f3; id_funct7 = 7'h0;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_immediate = imm;
    endtask

    task automatic drive_random();
        logic [6:0] ops [10];
        ops = '{ADD_OP, IMM_OP, AUIPC_OP, LUI_OP, JAL_OP, LOAD_OP, BR_OP, ST_OP, 7'b1100111, 7'h0};
        id_valid = ($urandom_range(0, 9) != 0);
        id_pc = $urandom; id_opcode = ops[$urandom_range(0, 9)];
        id_funct3 = 3'($urandom_range(0, 7)); id_funct7 = 7'($urandom_range(0, 127));
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_immediate = $urandom;
        flush = ($urandom_range(0, 15) == 0);
        stall_in = ($urandom_range(0, 7) == 0);
        exmem_rd = 5'($urandom_range(0, 7)); exmem_regwrite = 1'($urandom_range(0, 1));
        exmem_result = $urandom;
        memwb_rd = 5'($urandom_range(0, 7)); memwb_regwrite = 1'($urandom_range(0, 1));
        memwb_result = $urandom;
    endtask

    initial begin
        m = '0;
        idle();
        reset = 1;
        @(negedge clk);
        settle("reset");
        reset = 0;

        // Reset lands while an ADD sits in EX.
        drive(ADD_OP, 3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0);
        settle("add_in");
        tick();
        idle();
        settle("add_held");
        chk("add_present", 32'(ex_valid), 32'd1);
        reset = 1;
        settle("mid_reset");
        chk("mid_reset_op1", ex_operand1, 32'h0);
        reset = 0;

        // EX/MEM beats MEM/WB.
        drive(ADD_OP, 3'b000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h9, 32'h0);
        settle("fwd_cap");
        tick();
        idle();
        exmem_rd = 5'd1; exmem_regwrite = 1; exmem_result = 32'h64;
        memwb_rd = 5'd1; memwb_regwrite = 1; memwb_result = 32'h7;
        settle("fwd");
        chk("exmem_wins", ex_operand1, 32'h64);

        // Load-use costs one bubble, then the ADD is taken.
        idle();
        drive(LOAD_OP, 3'b010, 5'd2, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4);
        settle("lw_cap");
        tick();
        drive(ADD_OP, 3'b000, 5'd5, 5'd1, 5'd6, 32'h1, 32'h2, 32'h0);
        settle("lu_detect");
        chk("lu_stall", 32'(hazard_stall), 32'd1);
        tick();
        settle("lu_bubble");
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_stall", 32'(hazard_stall), 32'd0);
        tick();
        idle();
        settle("lu_taken");
        chk("lu_taken_valid", 32'(ex_valid), 32'd1);
        chk("lu_taken_rd", 32'(ex_rd), 32'd6);

        // Flush wins over both stall_in and the load-use hazard.
        drive(LOAD_OP, 3'b010, 5'd2, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4);
        settle("lw2_cap");
        tick();
        drive(ADD_OP, 3'b000, 5'd5, 5'd1, 5'd6, 32'h1, 32'h2, 32'h0);
        flush = 1; stall_in = 1;
        settle("flush_stall");
        chk("flush_no_hazard", 32'(hazard_stall), 32'd0);
        tick();
        idle();
        settle("after_flush");
        chk("flush_bubble", 32'(ex_valid), 32'd0);

        // SLLI x2,x1,3 with x1=1.
        drive(IMM_OP, 3'b001, 5'd1, 5'd3, 5'd2, 32'h1, 32'hDEAD, 32'h3);
        settle("slli_cap");
        tick();
        idle();
        settle("slli");
        chk("slli_op2", ex_operand2, 32'h3);
        chk("slli_alu", ex_operand1 << ex_operand2[4:0], 32'h8);

        // x0 is never forwarded.
        drive(ADD_OP, 3'b000, 5'd0, 5'd7, 5'd4, 32'h55, 32'h11, 32'h0);
        settle("x0_cap");
        tick();
        idle();
        exmem_rd = 5'd0; exmem_regwrite = 1; exmem_result = 32'hFF;
        settle("x0");
        chk("x0_op1", ex_operand1, 32'h0);

        // Writeback bypass at capture.
        idle();
        drive(ADD_OP, 3'b000, 5'd0, 5'd7, 5'd4, 32'h0, 32'h0, 32'h0);
        memwb_rd = 5'd7; memwb_regwrite = 1; memwb_result = 32'h2A;
        settle("wb_cap");
        tick();
        idle();
        settle("wb");
        chk("wb_op2", ex_operand2, 32'h2A);

        for (int i = 0; i < 400; i++) begin
            drive_random();
            if ($urandom_range(0, 59) == 0) begin
                reset = 1;
                settle("rnd_reset");
                reset = 0;
            end
            settle("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
